// File: rtl/digi_pkg.sv
// Shared seven-segment constants: hex font, all-off codes, anode encoder.
// Used by digi_scan (optional DIGI_SCAN_LZ_BLANK_EN) and digi_hex7.
package digi_pkg;

  localparam logic [6:0]  SEG_OFF  = 7'h7F;
  localparam logic [11:0] DIGI_OFF = 12'hFFF;

  // Active-high gfedcba; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [3:0] anode_sel(
    input logic [1:0] idx
  );
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/digi_hex7.sv
// Combinational hex nibble to active-high seven-segment pattern.
// Pure table lookup into the shared font.
module digi_hex7
  import digi_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = FONT[nib];

endmodule

// File: rtl/digi_scan.sv
// Four-digit seven-segment scanner with PWM brightness.
// Optional leading-zero blanking: define DIGI_SCAN_LZ_BLANK_EN.
module digi_scan
  import digi_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iLoad,
  input  logic [15:0] iValue,
  input  logic [3:0]  iDpMask,
  input  logic [2:0]  iBright,
  output logic [11:0] oDigi,
  output logic [1:0]  oSlot
);

  localparam int SLOT_LEN = SCAN_DIV / 8;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      shadow;
  logic [3:0]       dp_shadow;
  logic             wrap;
  logic             lit;
  logic             blank;
  logic [3:0]       nib;
  logic [6:0]       seg;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      shadow    <= '0;
      dp_shadow <= '0;
    end else if (iLoad) begin
      shadow    <= iValue;
      dp_shadow <= iDpMask;
    end
  end

  assign wrap = (cnt == CNT_MAX);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (wrap) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // phase <= bright, phrased as a compare against the slot boundary
  assign lit = int'(cnt) < (int'(iBright) + 1) * SLOT_LEN;

  assign nib = shadow[idx*4 +: 4];

  digi_hex7 u_hex7 (
    .nib (nib),
    .seg (seg)
  );

`ifdef DIGI_SCAN_LZ_BLANK_EN
  always_comb begin
    blank = 1'b0;
    unique case (idx)
      2'd0: blank = 1'b0;
      2'd1: blank = (shadow[15:4]  == 12'h000);
      2'd2: blank = (shadow[15:8]  == 8'h00);
      2'd3: blank = (shadow[15:12] == 4'h0);
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oDigi <= DIGI_OFF;
      oSlot <= '0;
    end else begin
      oSlot <= idx;
      if (lit) begin
        oDigi <= {anode_sel(idx),
                  ~dp_shadow[idx],
                  blank ? SEG_OFF : ~seg};
      end else begin
        oDigi <= DIGI_OFF;
      end
    end
  end

endmodule

// File: doc/digi_scan.md
Name: digi_scan

Overview:
- Four-digit, seven-segment display scanner driving the board's 12-bit oDigi pin bus.
- Downstream consumer of the single-cycle CPU's display peripheral register. The CPU (or FPGA top) presents a 16-bit hex value plus decimal-point mask and strobes iLoad.
- Block latches the value, time-multiplexes digits with a prescaler, decodes hex to segments and applies PWM brightness.
- All outputs are registered.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot; must be a multiple of 8 and >= 8.
- CNT_W, 16, prescaler width; must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
- iClk  input  1  system clock, rising-edge.
- iRst_n  input  1  asynchronous active-low reset.
- iLoad  input  1  single-cycle strobe; capture iValue/iDpMask.
- iValue  input  16  hex value; nibble i shown on digit i (digit 0 = rightmost).
- iDpMask  input  4  decimal point enable per digit, 1 = lit.
- iBright  input  3  brightness 0..7; 7 = full on; sampled live, not latched.
- oDigi  output  12  [11:8] anodes active-low one-hot; [7] dp active-low; [6:0] segments gfedcba active-low.
- oSlot  output  2  index of digit currently scanned (debug/LED).

Behaviour:
- Reset (async, iRst_n=0):
  - shadow value = 16'h0000, shadow dp = 4'b0000.
  - prescaler = 0, digit index = 0.
  - oDigi = 12'hFFF (all dark), oSlot = 0.
  - Asserting reset mid-scan forces this state immediately. First lit output appears on the first clock edge after release.
- Load:
  - When iLoad=1 at a rising edge, shadow <= iValue and dp shadow <= iDpMask.
  - iLoad held high reloads every cycle; this is legal.
- Prescaler and digit index:
  - Prescaler counts 0..SCAN_DIV-1 and wraps to 0.
  - On the wrap edge, digit index increments mod 4 (3 -> 0).
- Phase and lit window:
  - phase = prescaler / (SCAN_DIV/8), range 0..7.
  - Digit is lit when phase <= iBright; otherwise the whole oDigi = 12'hFFF.
  - iBright=0 gives 1/8 duty; iBright=7 gives full duty.
- Output register:
  - oDigi and oSlot are updated every edge from current-cycle counters and shadows, giving one-cycle latency.
  - Lit digit i: anodes = ~(4'b0001 << i); seg = ~font(shadow[4i+3:4i]); dp = ~dp_shadow[i].
- Simultaneous load and digit advance in the same edge: the output on the following edge uses the new shadow and new index.
- Font: standard hex.
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71 (active-high gfedcba; inverted at the pin).
- No state machine beyond the two counters. No illegal states are reachable; the index is 2 bits.

Optional Feature:
- Macro: DIGI_SCAN_LZ_BLANK_EN
- Defined (leading-zero blanking):
  - Each digit i>0 whose nibble and all higher nibbles are zero has its segments forced dark (seg = 7'h7F).
  - The anode still scans and the dp still follows the mask.
  - Digit 0 is never blanked.
  - Blanking is evaluated from the shadow, so it follows the same one-cycle latency.
- Undefined: all four digits always show their nibble, including zeros.

Decomposition:
- Shared package digi_pkg:
  - 16-entry hex font constant.
  - Blank/all-off constants: SEG_OFF=7'h7F, DIGI_OFF=12'hFFF.
  - Anode one-hot encoding function.
- Sub-module digi_hex7: combinational nibble -> active-high segments, using the package font. Reused by any future display block.

Test Plan (SCAN_DIV=16 for simulation):
- Reset release, no load:
  - Required: oDigi = 12'hFFF while in reset.
  - Required: first lit cycle shows anodes 1110, seg ~3F (0x40), dp 1.
  - Required: index advances every 16 cycles: 0, 1, 2, 3, 0.
- Load iValue=16'h12AF, iDpMask=4'b0100, iBright=7:
  - Required per digit 0..3: seg ~71, ~77, ~5B, ~06.
  - Required: dp low only on digit 2.
  - Required: anodes 1110, 1101, 1011, 0111.
- iBright=3:
  - Required: each slot is lit for prescaler 0..7 and oDigi = 12'hFFF for prescaler 8..15, observed one cycle later.
  - Repeat with iBright=0: lit only for prescaler 0..1.
- iLoad pulsed on the same edge as the 3->0 wrap with iValue=16'h0005:
  - Required: the next output edge shows digit 0 with seg ~6D. No cycle of the stale value on digit 0.
- Assert iRst_n=0 mid-slot during digit 2:
  - Required: oDigi = 12'hFFF immediately (asynchronous), shadow cleared.
  - Required after release: scan restarts at digit 0 with 0.
- With DIGI_SCAN_LZ_BLANK_EN, iValue=16'h0030:
  - Required: digits 2 and 3 have seg 7F; digit 1 shows ~4F; digit 0 shows ~3F.
  - Without the macro: digits 2 and 3 show ~3F.
